// File: rtl/cs_pkg.sv
// Shared constants and FSM state type for the CS frame sequencer.
package cs_pkg;

  localparam int XW            = 8;
  localparam int YW            = 10;
  localparam int WIN           = 9;
  localparam int CS_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    PRIME,
    STREAM,
    DRAIN,
    ERR
  } cs_seq_state_t;

endpackage

// File: rtl/cs_seq_fifo.sv
// Synchronous prefetch FIFO with first-word fall-through read and flush.
module cs_seq_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cs_seq.sv
// cs_seq: clears the CS window per frame and streams frame_len samples into it from a prefetch FIFO.
// Optional macro CS_SEQ_STATS_EN adds saturating frames_ok / underruns counters.
//
// state  | meaning
// IDLE   | waiting for start, FIFO prefetching
// CLR    | cs_reset held for CS_RST_CYCLES
// PRIME  | wait for a full FIFO or enough data for the rest of the frame
// STREAM | one sample per cycle into cs_x
// DRAIN  | wait LAT cycles for the last result, pulse done
// ERR    | underrun: flush FIFO, reset CS, back to IDLE
module cs_seq #(
  parameter int XW    = cs_pkg::XW,
  parameter int YW    = cs_pkg::YW,
  parameter int WIN   = cs_pkg::WIN,
  parameter int LAT   = 1,
  parameter int DEPTH = 16,
  parameter int LENW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LENW-1:0] frame_len,
  input  logic            s_valid,
  input  logic [XW-1:0]   s_data,
  output logic            s_ready,
  output logic            cs_reset,
  output logic [XW-1:0]   cs_x,
  input  logic [YW-1:0]   cs_y,
  output logic            m_valid,
  output logic [YW-1:0]   m_data,
  output logic [LENW-1:0] m_index,
  output logic            busy,
  output logic            done,
  output logic            underrun,
  output logic            cfg_err
`ifdef CS_SEQ_STATS_EN
  ,
  output logic [15:0]     frames_ok,
  output logic [15:0]     underruns
`endif
);
  import cs_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(LAT + CS_RST_CYCLES + 1);

  cs_seq_state_t   state;
  cs_seq_state_t   next_state;
  logic [TW-1:0]   cnt;
  logic [LENW-1:0] len;
  logic [LENW-1:0] issued;
  logic [CW-1:0]   count;
  logic [XW-1:0]   head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            flush;
  logic            accept;
  logic            enter_err;
  logic [LAT:0]    tag;

  cs_seq_fifo #(
    .W     (XW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Ready comes from the registered count, so a push against a full FIFO is refused even if it pops.
  assign s_ready   = !reset && !full && (state != ERR);
  assign push      = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign m_valid   = tag[LAT];
  assign m_data    = m_valid ? cs_y : '0;
  assign enter_err = (state == STREAM) && (next_state == ERR);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    flush      = 1'b0;
    done       = 1'b0;
    cfg_err    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (frame_len >= LENW'(WIN)) begin
            accept     = 1'b1;
            next_state = CLR;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end
      CLR: begin
        if (cnt == TW'(CS_RST_CYCLES - 1)) next_state = PRIME;
      end
      PRIME: begin
        if ((count == CW'(DEPTH)) || (LENW'(count) >= (len - issued))) next_state = STREAM;
      end
      STREAM: begin
        if (empty) begin
          next_state = ERR;
        end else begin
          pop = 1'b1;
          if ((issued + LENW'(1)) == len) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == TW'(LAT)) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      ERR: begin
        flush = 1'b1;
        if (cnt == TW'(CS_RST_CYCLES - 1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      issued   <= '0;
      cs_x     <= '0;
      cs_reset <= 1'b1;
      tag      <= '0;
      m_index  <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= (next_state != state) ? '0 : cnt + TW'(1);
      cs_reset <= (next_state == CLR) || (next_state == ERR);
      cs_x     <= pop ? head : '0;
      // tag[0] is aligned with cs_x; LAT further stages line it up with cs_y.
      tag      <= {tag[LAT-1:0], pop && (issued >= LENW'(WIN - 1))};
      if (accept) begin
        len    <= frame_len;
        issued <= '0;
      end else if (pop) begin
        issued <= issued + LENW'(1);
      end
      if (accept)       m_index <= '0;
      else if (m_valid) m_index <= m_index + LENW'(1);
      if (accept)         underrun <= 1'b0;
      else if (enter_err) underrun <= 1'b1;
    end
  end

`ifdef CS_SEQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_ok <= '0;
      underruns <= '0;
    end else begin
      if (done && (frames_ok != 16'hFFFF))      frames_ok <= frames_ok + 16'd1;
      if (enter_err && (underruns != 16'hFFFF)) underruns <= underruns + 16'd1;
    end
  end
`endif

endmodule
